// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: shares one pipelined main-memory port between I-cache fills,
// D-cache fills and D-cache write-through stores.
//   clk, rst_n                     clock; synchronous active-low reset
//   i_miss/i_miss_addr             I-cache block-fill request (level, held until i_fill_done)
//   d_miss/d_miss_addr             D-cache block-fill request (level, held until d_fill_done)
//   d_wr_req/d_wr_addr/d_wr_data   D-cache store (level, held until d_wr_done)
//   mem_rdata/mem_valid            memory read return, MEM_LAT cycles after each read
//   mem_en/mem_wr/mem_addr/mem_wdata  memory access issued this cycle
//   fill_we/fill_word/fill_data    returned word written into the granted cache
//   fill_icache/fill_dcache        target of the fill in progress
//   i_fill_done/d_fill_done/d_wr_done  one-cycle completion pulses
//   busy                           arbiter is not idle
module mem_fill_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = 8,
  parameter int MEM_LAT   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              fill_we,
  output logic [2:0]        fill_word,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_icache,
  output logic              fill_dcache,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_done,
  output logic              busy
);
  localparam int CW = $clog2(BLK_WORDS) + 1;
  localparam logic [CW-1:0] NW    = CW'(BLK_WORDS);
  localparam logic [CW-1:0] LASTR = CW'(BLK_WORDS - 1);
  // The block geometry (8 words of 2 bytes, 16-byte aligned base) is built into the
  // address math, and responses are only ever expected after the request cycle.
  if (MEM_LAT < 1 || BLK_WORDS != 8) begin : gBadParams
    $error("mem_fill_arbiter: unsupported MEM_LAT/BLK_WORDS");
  end
  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} stateT;
  stateT             state;
  logic              tgtI;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] wdReg;
  logic [CW-1:0]     issueCnt;
  logic [CW-1:0]     rcvCnt;
  logic              issuing;
  // Issue and receive run independently: reads go out back-to-back while the
  // pipelined memory returns earlier words, so the two counters overlap in FILL.
  always_comb begin
    issuing     = state == FILL && issueCnt < NW;
    mem_en      = issuing || state == WRITE;
    mem_wr      = state == WRITE;
    mem_addr    = issuing ? addrReg + ADDR_W'({issueCnt, 1'b0}) : (state == WRITE ? addrReg : '0);
    mem_wdata   = state == WRITE ? wdReg : '0;
    fill_we     = state == FILL && mem_valid && rcvCnt < NW;
    fill_word   = fill_we ? rcvCnt[CW-2:0] : '0;
    fill_data   = mem_rdata;
    fill_icache = state == FILL && tgtI;
    fill_dcache = state == FILL && !tgtI;
    i_fill_done = state == DONE && tgtI;
    d_fill_done = state == DONE && !tgtI;
    d_wr_done   = state == WRITE;
    busy        = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tgtI     <= 1'b0;
      addrReg  <= '0;
      wdReg    <= '0;
      issueCnt <= '0;
      rcvCnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_wr_req) begin
            state   <= WRITE;
            addrReg <= d_wr_addr;
            wdReg   <= d_wr_data;
          end else if (d_miss || i_miss) begin
            state   <= FILL;
            tgtI    <= !d_miss;
            addrReg <= d_miss ? {d_miss_addr[ADDR_W-1:4], 4'b0} : {i_miss_addr[ADDR_W-1:4], 4'b0};
          end
        end
        WRITE: state <= IDLE;
        FILL: begin
          if (issuing) issueCnt <= issueCnt + CW'(1);
          if (fill_we) begin
            rcvCnt <= rcvCnt + CW'(1);
            if (rcvCnt == LASTR) state <= DONE;
          end
        end
        default: begin
          issueCnt <= '0;
          rcvCnt   <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb_mem_fill_arbiter: self-checking bench for mem_fill_arbiter with a pipelined memory model.
module tb_mem_fill_arbiter;
  localparam int L = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        mem_en, mem_wr, fill_we, fill_icache, fill_dcache;
  logic        i_fill_done, d_fill_done, d_wr_done, busy;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic [2:0]  fill_word;

  mem_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .BLK_WORDS(8), .MEM_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fill_we(fill_we), .fill_word(fill_word), .fill_data(fill_data),
    .fill_icache(fill_icache), .fill_dcache(fill_dcache),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_done(d_wr_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memF(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // memory: fixed-latency read pipeline, cleared by the shared reset
  logic        pv [L];
  logic [15:0] pa [L];
  logic        forceValid = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
      end
    end else begin
      pv[0] <= mem_en && !mem_wr;
      pa[0] <= mem_addr;
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end
  assign mem_valid = pv[L-1] | forceValid;
  assign mem_rdata = pv[L-1] ? memF(pa[L-1]) : 16'h0000;

  // reference model: one active transaction described by kind and grant cycle;
  // every output is a plain function of the cycle offset from the grant
  typedef struct packed {
    logic en, wr;
    logic [15:0] addr, wdata;
    logic we;
    logic [2:0] word;
    logic ic, dc, idn, ddn, wdn, busy;
  } outT;

  int          cyc = 0;
  int          mKind = 0;  // 0 none, 1 store, 2 D fill, 3 I fill
  int          mG = 0;
  logic [15:0] mBase = '0, mWA = '0, mWD = '0;

  function automatic int dur(input int k);
    return k == 1 ? 2 : L + 10;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) mKind <= 0;
    else if (mKind == 0 || cyc - mG >= dur(mKind)) begin
      mG <= cyc;
      if (d_wr_req) begin
        mKind <= 1; mWA <= d_wr_addr; mWD <= d_wr_data;
      end else if (d_miss) begin
        mKind <= 2; mBase <= d_miss_addr & 16'hFFF0;
      end else if (i_miss) begin
        mKind <= 3; mBase <= i_miss_addr & 16'hFFF0;
      end else mKind <= 0;
    end
  end

  function automatic outT expOut();
    outT e;
    int d;
    e = '0;
    d = cyc - mG;
    if (mKind == 1 && d == 1) begin
      e.en = 1; e.wr = 1; e.addr = mWA; e.wdata = mWD; e.wdn = 1; e.busy = 1;
    end else if (mKind >= 2) begin
      if (d >= 1 && d <= L + 9) e.busy = 1;
      if (d >= 1 && d <= L + 8) begin
        e.ic = mKind == 3; e.dc = mKind == 2;
      end
      if (d >= 1 && d <= 8) begin
        e.en = 1; e.addr = mBase + 16'(2 * (d - 1));
      end
      if (d >= L + 1 && d <= L + 8) begin
        e.we = 1; e.word = 3'(d - L - 1);
      end
      if (d == L + 9) begin
        e.idn = mKind == 3; e.ddn = mKind == 2;
      end
    end
    return e;
  endfunction

  int nChk = 0, nPass = 0;
  logic chk = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic outT actOut();
    return {mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_word,
            fill_icache, fill_dcache, i_fill_done, d_fill_done, d_wr_done, busy};
  endfunction

  // cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    outT e;
    if (chk) begin
      e = expOut();
      check("outputs", 64'(actOut()), 64'(e));
      if (e.we) check("fill_data", 64'(fill_data), 64'(memF(mBase + {12'h000, e.word, 1'b0})));
    end
  end

  // per-step observation of the DUT, plus cache-side request behaviour
  logic        rnd = 1'b0;
  logic        seen, wrSeen, weSeen;
  logic [15:0] firstAddr, wrAddr, wrData;
  logic        firstWr;
  logic [2:0]  firstWord;
  int          nDone, lastDone, wrCyc, weCnt;

  task automatic clearObs();
    seen = 0; wrSeen = 0; weSeen = 0; nDone = 0; lastDone = -1; wrCyc = -1; weCnt = 0;
  endtask

  task automatic step();
    outT e;
    @(negedge clk);
    e = expOut();
    if (e.wdn) d_wr_req = 0;
    if (e.ddn) d_miss = 0;
    if (e.idn) i_miss = 0;
    if (mem_en && !seen) begin
      seen = 1; firstAddr = mem_addr; firstWr = mem_wr;
    end
    if (mem_wr && !wrSeen) begin
      wrSeen = 1; wrCyc = cyc; wrAddr = mem_addr; wrData = mem_wdata;
    end
    if (fill_we) begin
      weCnt++;
      if (!weSeen) begin
        weSeen = 1; firstWord = fill_word;
      end
    end
    if (i_fill_done || d_fill_done || d_wr_done) begin
      nDone++; lastDone = cyc;
    end
    if (rnd) begin
      if (!d_wr_req && $urandom_range(0, 7) == 0) begin
        d_wr_req = 1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
      end
      if (!d_miss && $urandom_range(0, 7) == 0) begin
        d_miss = 1; d_miss_addr = 16'($urandom);
      end
      if (!i_miss && $urandom_range(0, 7) == 0) begin
        i_miss = 1; i_miss_addr = 16'($urandom);
      end
    end
  endtask

  typedef struct {
    logic w, d, i;
    logic [15:0] wa, wd, da, ia;
    logic [15:0] expFirstAddr;
    logic expFirstWr;
    int expDones;
    int expLastDone;
  } vecT;

  initial begin
    vecT vec [6];
    int c0;
    logic found;
    vec[0] = '{0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0036, 16'h0030, 0, 1, 13};
    vec[1] = '{0, 1, 1, 16'h0000, 16'h0000, 16'h2208, 16'h0100, 16'h2200, 0, 2, 27};
    vec[2] = '{1, 1, 1, 16'h4002, 16'hBEEF, 16'h2208, 16'h0100, 16'h4002, 1, 3, 29};
    vec[3] = '{0, 1, 0, 16'h0000, 16'h0000, 16'h1235, 16'h0000, 16'h1230, 0, 1, 13};
    vec[4] = '{1, 0, 0, 16'h00FF, 16'h1234, 16'h0000, 16'h0000, 16'h00FF, 1, 1, 1};
    vec[5] = '{1, 0, 1, 16'h7777, 16'h0F0F, 16'h0000, 16'hFFFE, 16'h7777, 1, 2, 15};

    @(negedge clk);
    chk = 1;
    check("reset_outputs", 64'(actOut()), 64'd0);
    rst_n = 1;

    foreach (vec[n]) begin
      step();
      d_wr_req = vec[n].w; d_wr_addr = vec[n].wa; d_wr_data = vec[n].wd;
      d_miss = vec[n].d; d_miss_addr = vec[n].da;
      i_miss = vec[n].i; i_miss_addr = vec[n].ia;
      c0 = cyc;
      clearObs();
      repeat (40) step();
      check($sformatf("vec%0d_first_addr", n), 64'(firstAddr), 64'(vec[n].expFirstAddr));
      check($sformatf("vec%0d_first_wr", n), 64'(firstWr), 64'(vec[n].expFirstWr));
      check($sformatf("vec%0d_dones", n), 64'(nDone), 64'(vec[n].expDones));
      check($sformatf("vec%0d_last_done", n), 64'(lastDone - c0), 64'(vec[n].expLastDone));
    end

    // store arriving during a D fill waits for the fill to finish
    step();
    d_miss = 1; d_miss_addr = 16'h2208;
    c0 = cyc;
    clearObs();
    repeat (3) step();
    d_wr_req = 1; d_wr_addr = 16'h4002; d_wr_data = 16'hBEEF;
    repeat (25) step();
    check("store_wait_cycle", 64'(wrCyc - c0), 64'd15);
    check("store_addr", 64'(wrAddr), 64'h4002);
    check("store_data", 64'(wrData), 64'hBEEF);
    check("store_dones", 64'(nDone), 64'd2);

    // reset at fill word 3 abandons the fill; held request restarts it
    step();
    i_miss = 1; i_miss_addr = 16'h0036;
    c0 = cyc;
    found = 0;
    for (int t = 0; t < 30 && !found; t++) begin
      step();
      if (fill_we && fill_word == 3'd3) found = 1;
    end
    check("rst_reach_word3", 64'(found), 64'd1);
    rst_n = 0;
    clearObs();
    step();
    rst_n = 1;
    check("rst_outputs_zero", 64'(actOut()), 64'd0);
    check("rst_no_done", 64'(nDone), 64'd0);
    clearObs();
    repeat (20) step();
    check("rst_restart_word0", 64'(firstWord), 64'd0);
    check("rst_restart_words", 64'(weCnt), 64'd8);
    check("rst_restart_dones", 64'(nDone), 64'd1);
    check("rst_restart_done_cycle", 64'(lastDone - c0), 64'd22);

    // randomized traffic against the model
    rnd = 1;
    repeat (3000) step();
    rnd = 0;
    for (int t = 0; t < 200 && (i_miss || d_miss || d_wr_req || mKind != 0); t++) step();
    check("drain_idle", 64'(i_miss || d_miss || d_wr_req || mKind != 0), 64'd0);

    // spurious mem_valid while idle is ignored
    step();
    forceValid = 1;
    clearObs();
    repeat (6) step();
    forceValid = 0;
    check("idle_valid_no_we", 64'(weCnt), 64'd0);
    check("idle_valid_no_done", 64'(nDone), 64'd0);

    chk = 0;
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
